// File: rtl/bsv_uart_spi_bridge.sv
// bsv_uart_spi_bridge
//   UART host link bridged to two SPI mode-0 masters (SPI0 = LoRa radio,
//   SPI1 = FRAM). The host sends a command byte (upper nibble 4'hA, bit0 =
//   device, bit1 = release CS afterwards), then a data byte. One full-duplex
//   SPI byte is exchanged and the MISO byte is echoed back over UART.
//
// Ports
//   CLK                          system clock (48 MHz)
//   RST_N                        synchronous reset, active HIGH
//   blue / green / red           status LEDs (toggle per transfer / ~spi0_cs / ~spi1_cs)
//   spi0_sclk/mosi/miso/cs       LoRa SPI port, cs active-low
//   spi1_sclk/mosi/miso/cs       FRAM SPI port, cs active-low
//   serial_txd / serial_rxd      UART 8N1, LSB first, UART_DIV clocks per bit
module bsv_uart_spi_bridge #(
  parameter int UART_DIV = 417,
  parameter int SPI_HALF = 24
) (
  input  logic CLK,
  input  logic RST_N,
  output logic blue,
  output logic green,
  output logic red,
  output logic spi0_sclk,
  output logic spi0_mosi,
  input  logic spi0_miso,
  output logic spi0_cs,
  output logic spi1_sclk,
  output logic spi1_mosi,
  input  logic spi1_miso,
  output logic spi1_cs,
  output logic serial_txd,
  input  logic serial_rxd
);

  localparam logic [15:0] UDIV_M1  = 16'(UART_DIV - 1);
  localparam logic [15:0] UHALF_M1 = 16'(UART_DIV / 2 - 1);
  localparam logic [7:0]  SHALF_M1 = 8'(SPI_HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_XFER, S_RESP} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {SP_LOW, SP_HIGH, SP_TAIL} spi_phase_t;

  // UART RX
  logic       rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d, rxd_prev_q, rxd_prev_d;
  rx_state_t  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  // UART TX
  logic       tx_busy_q, tx_busy_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [9:0] tx_frame_q, tx_frame_d;
  logic       tx_start;
  // Command FSM and SPI engine
  state_t     state_q, state_d;
  spi_phase_t spi_phase_q, spi_phase_d;
  logic       dev_q, dev_d, rel_q, rel_d;
  logic [7:0] spi_cnt_q, spi_cnt_d, spi_sh_q, spi_sh_d;
  logic [2:0] spi_bit_q, spi_bit_d;
  logic       miso_bit_q, miso_bit_d, sclk_q, sclk_d;
  logic       cs0_q, cs0_d, cs1_q, cs1_d, blue_q, blue_d;
  logic       mosi_bit;

  always_comb begin
    rxd_meta_d  = serial_rxd;
    rxd_sync_d  = rxd_meta_q;
    rxd_prev_d  = rxd_sync_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_busy_d   = tx_busy_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_frame_d  = tx_frame_q;
    tx_start    = 1'b0;
    state_d     = state_q;
    spi_phase_d = spi_phase_q;
    dev_d       = dev_q;
    rel_d       = rel_q;
    spi_cnt_d   = spi_cnt_q;
    spi_sh_d    = spi_sh_q;
    spi_bit_d   = spi_bit_q;
    miso_bit_d  = miso_bit_q;
    sclk_d      = sclk_q;
    cs0_d       = cs0_q;
    cs1_d       = cs1_q;
    blue_d      = blue_q;

    // UART receiver: bit centres are found by waiting half a bit after the
    // falling edge, then stepping a whole bit at a time.
    unique case (rx_state_q)
      RX_IDLE: if (rxd_prev_q && !rxd_sync_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (rx_cnt_q == UHALF_M1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;  // glitch, not a start bit
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_DATA: if (rx_cnt_q == UDIV_M1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_STOP: if (rx_cnt_q == UDIV_M1) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (rxd_sync_q) begin            // low stop bit: framing error, drop
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
        end
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      default: rx_state_d = RX_IDLE;
    endcase

    unique case (state_q)
      S_IDLE: if (rx_valid_q && rx_data_q[7:4] == 4'hA) begin
        dev_d   = rx_data_q[0];
        rel_d   = rx_data_q[1];
        // Only one chip select may be held: drop the other device's CS now.
        if (rx_data_q[0]) cs0_d = 1'b1;
        else              cs1_d = 1'b1;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: if (rx_valid_q) begin
        spi_sh_d    = rx_data_q;
        spi_phase_d = SP_LOW;
        spi_cnt_d   = '0;
        spi_bit_d   = '0;
        sclk_d      = 1'b0;
        if (dev_q) cs1_d = 1'b0;
        else       cs0_d = 1'b0;
        state_d     = S_XFER;
      end
      S_XFER: begin
        unique case (spi_phase_q)
          SP_LOW: if (spi_cnt_q == SHALF_M1) begin
            spi_cnt_d   = '0;
            sclk_d      = 1'b1;
            miso_bit_d  = dev_q ? spi1_miso : spi0_miso;
            spi_phase_d = SP_HIGH;
          end else spi_cnt_d = spi_cnt_q + 8'd1;
          SP_HIGH: if (spi_cnt_q == SHALF_M1) begin
            // Falling edge: shift out the next MOSI bit, shift in the sample.
            spi_cnt_d   = '0;
            sclk_d      = 1'b0;
            spi_sh_d    = {spi_sh_q[6:0], miso_bit_q};
            spi_bit_d   = spi_bit_q + 3'd1;
            spi_phase_d = (spi_bit_q == 3'd7) ? SP_TAIL : SP_LOW;
          end else spi_cnt_d = spi_cnt_q + 8'd1;
          SP_TAIL: if (!rel_q || spi_cnt_q == SHALF_M1) begin
            if (rel_q) begin
              if (dev_q) cs1_d = 1'b1;
              else       cs0_d = 1'b1;
            end
            spi_cnt_d = '0;
            blue_d    = ~blue_q;
            tx_start  = 1'b1;
            state_d   = S_RESP;
          end else spi_cnt_d = spi_cnt_q + 8'd1;
          default: spi_phase_d = SP_LOW;
        endcase
      end
      S_RESP: if (!tx_busy_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // UART transmitter: a 10-bit frame shifted out LSB first; ones are shifted
    // in behind it so the line rests high once the frame has gone.
    if (tx_start) begin
      tx_frame_d = {1'b1, spi_sh_q, 1'b0};
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == UDIV_M1) begin
        tx_cnt_d   = '0;
        tx_frame_d = {1'b1, tx_frame_q[9:1]};
        if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
        else                  tx_bit_d  = tx_bit_q + 4'd1;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      rxd_meta_q <= 1'b1;  rxd_sync_q <= 1'b1;  rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0;
      rx_shift_q <= '0;    rx_data_q <= '0;     rx_valid_q <= 1'b0;
      tx_busy_q  <= 1'b0;  tx_cnt_q <= '0;      tx_bit_q <= '0;
      tx_frame_q <= '1;
      state_q    <= S_IDLE; spi_phase_q <= SP_LOW;
      dev_q      <= 1'b0;  rel_q <= 1'b0;       spi_cnt_q <= '0;
      spi_sh_q   <= '0;    spi_bit_q <= '0;     miso_bit_q <= 1'b0;
      sclk_q     <= 1'b0;  cs0_q <= 1'b1;       cs1_q <= 1'b1;
      blue_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd_meta_d; rxd_sync_q <= rxd_sync_d; rxd_prev_q <= rxd_prev_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d;     rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d; rx_data_q <= rx_data_d;   rx_valid_q <= rx_valid_d;
      tx_busy_q  <= tx_busy_d;  tx_cnt_q <= tx_cnt_d;     tx_bit_q <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      state_q    <= state_d;    spi_phase_q <= spi_phase_d;
      dev_q      <= dev_d;      rel_q <= rel_d;           spi_cnt_q <= spi_cnt_d;
      spi_sh_q   <= spi_sh_d;   spi_bit_q <= spi_bit_d;   miso_bit_q <= miso_bit_d;
      sclk_q     <= sclk_d;     cs0_q <= cs0_d;           cs1_q <= cs1_d;
      blue_q     <= blue_d;
    end
  end

  // MOSI carries the current MSB only while bits are being clocked; the
  // selected device gates which port sees sclk/mosi, the other stays at 0.
  assign mosi_bit   = (state_q == S_XFER) && (spi_phase_q != SP_TAIL) && spi_sh_q[7];
  assign spi0_sclk  = sclk_q & ~dev_q;
  assign spi0_mosi  = mosi_bit & ~dev_q;
  assign spi1_sclk  = sclk_q & dev_q;
  assign spi1_mosi  = mosi_bit & dev_q;
  assign spi0_cs    = cs0_q;
  assign spi1_cs    = cs1_q;
  assign serial_txd = tx_frame_q[0];
  assign blue       = blue_q;
  assign green      = ~cs0_q;
  assign red        = ~cs1_q;

endmodule

// File: tb/tb_bsv_uart_spi_bridge.sv
// Directed testbench for bsv_uart_spi_bridge. A UART bit period shorter than
// the 115200-baud default keeps the run short; SPI timing uses the default.
module tb_bsv_uart_spi_bridge;
  localparam int UDIV  = 64;
  localparam int SHALF = 24;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic serial_rxd = 1'b1;
  logic spi0_miso = 1'b0;
  logic spi1_miso = 1'b0;
  logic blue, green, red, spi0_sclk, spi0_mosi, spi0_cs;
  logic spi1_sclk, spi1_mosi, spi1_cs, serial_txd;

  bsv_uart_spi_bridge #(.UART_DIV(UDIV), .SPI_HALF(SHALF)) dut (
    .CLK(CLK), .RST_N(RST_N), .blue(blue), .green(green), .red(red),
    .spi0_sclk(spi0_sclk), .spi0_mosi(spi0_mosi), .spi0_miso(spi0_miso), .spi0_cs(spi0_cs),
    .spi1_sclk(spi1_sclk), .spi1_mosi(spi1_mosi), .spi1_miso(spi1_miso), .spi1_cs(spi1_cs),
    .serial_txd(serial_txd), .serial_rxd(serial_rxd)
  );

  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic mon_en = 1'b0;
  logic exp_blue = 1'b0;
  logic [7:0] uart_q[$];
  logic [7:0] resp0[$], resp1[$], mosi0_q[$], mosi1_q[$];
  int act0 = 0, act1 = 0, viol = 0, both_low = 0, cs1_rises = 0, rises0 = 0;
  int cs0_rise_cyc = 0, cs1_fall_cyc = 0, per0_min = 1000000, per0_max = 0, last_rise0 = 0;
  int nb0 = 0, nb1 = 0;
  logic [7:0] cur0 = 8'h00, cur1 = 8'h00, cap0 = 8'h00, cap1 = 8'h00;
  logic cs0_prev = 1'b1, cs1_prev = 1'b1, sclk0_prev = 1'b0, sclk1_prev = 1'b0;

  // SPI mode-0 slave models: MISO changes after SCLK falls, MOSI captured on rise.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (spi0_cs) begin
        nb0 = 0; spi0_miso = 1'b0;
        if (!cs0_prev) cs0_rise_cyc = cyc;
      end else begin
        if (cs0_prev) begin
          nb0 = 0;
          if (resp0.size() > 0) cur0 = resp0.pop_front(); else cur0 = 8'h00;
          spi0_miso = cur0[7];
        end
        if (spi0_sclk && !sclk0_prev) begin
          cap0 = {cap0[6:0], spi0_mosi};
          rises0++;
          if (nb0 > 0) begin
            if (cyc - last_rise0 < per0_min) per0_min = cyc - last_rise0;
            if (cyc - last_rise0 > per0_max) per0_max = cyc - last_rise0;
          end
          last_rise0 = cyc;
        end
        if (!spi0_sclk && sclk0_prev) begin
          nb0++;
          cur0 = {cur0[6:0], 1'b0};
          if (nb0 == 8) begin
            nb0 = 0; mosi0_q.push_back(cap0);
            if (resp0.size() > 0) cur0 = resp0.pop_front(); else cur0 = 8'h00;
          end
          spi0_miso = cur0[7];
        end
      end
      if (spi1_cs) begin
        nb1 = 0; spi1_miso = 1'b0;
        if (!cs1_prev) cs1_rises++;
      end else begin
        if (cs1_prev) begin
          nb1 = 0; cs1_fall_cyc = cyc;
          if (resp1.size() > 0) cur1 = resp1.pop_front(); else cur1 = 8'h00;
          spi1_miso = cur1[7];
        end
        if (spi1_sclk && !sclk1_prev) cap1 = {cap1[6:0], spi1_mosi};
        if (!spi1_sclk && sclk1_prev) begin
          nb1++;
          cur1 = {cur1[6:0], 1'b0};
          if (nb1 == 8) begin
            nb1 = 0; mosi1_q.push_back(cap1);
            if (resp1.size() > 0) cur1 = resp1.pop_front(); else cur1 = 8'h00;
          end
          spi1_miso = cur1[7];
        end
      end
      if (!spi0_cs || spi0_sclk || spi0_mosi) act0++;
      if (!spi1_cs || spi1_sclk || spi1_mosi) act1++;
      if ((spi0_cs && (spi0_sclk || spi0_mosi)) || (spi1_cs && (spi1_sclk || spi1_mosi))) viol++;
      if (!spi0_cs && !spi1_cs) both_low++;
    end
    cs0_prev = spi0_cs; cs1_prev = spi1_cs; sclk0_prev = spi0_sclk; sclk1_prev = spi1_sclk;
  end

  // UART receiver on serial_txd, sampling bit centres.
  initial begin
    logic [7:0] b;
    b = 8'h00;
    wait (mon_en);
    forever begin
      @(negedge CLK);
      if (serial_txd === 1'b0) begin
        repeat (UDIV / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (UDIV) @(negedge CLK);
          b[i] = serial_txd;
        end
        repeat (UDIV) @(negedge CLK);
        uart_q.push_back(b);
        $display("txn: uart reply 0x%02h stop=%b at cycle %0d", b, serial_txd, cyc);
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(negedge CLK);
    serial_rxd = 1'b0;
    repeat (UDIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      serial_rxd = b[i];
      repeat (UDIV) @(negedge CLK);
    end
    serial_rxd = stop;
    repeat (UDIV) @(negedge CLK);
    serial_rxd = 1'b1;
    repeat (UDIV) @(negedge CLK);
    $display("txn: uart sent 0x%02h stop=%b at cycle %0d", b, stop, cyc);
  endtask

  task automatic wait_reply(input int n, input int budget);
    int k;
    k = 0;
    while (uart_q.size() < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b1;
    serial_rxd = 1'b1;
    repeat (15) @(negedge CLK);
    RST_N = 1'b0;
    mon_en = 1'b1;
    act0 = 0; act1 = 0; viol = 0; both_low = 0;
    @(negedge CLK);
    vec_cnt++;
    if ({spi0_cs, spi1_cs, spi0_sclk, spi1_sclk, spi0_mosi, spi1_mosi, serial_txd} !== 7'b1100001) begin
      err_cnt++;
      $display("FAIL reset_pins: got %b want 1100001", {spi0_cs, spi1_cs, spi0_sclk, spi1_sclk, spi0_mosi, spi1_mosi, serial_txd});
    end
    vec_cnt++;
    if ({blue, green, red} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_leds: got %b want 000", {blue, green, red});
    end
    repeat (10000) @(negedge CLK);
    vec_cnt++;
    if (act0 + act1 != 0 || uart_q.size() != 0 || serial_txd !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_quiet: spi activity %0d uart bytes %0d txd %b, want 0 0 1", act0 + act1, uart_q.size(), serial_txd);
    end
  endtask

  task automatic test_spi0_single;
    logic [7:0] got;
    act1 = 0; per0_min = 1000000; per0_max = 0;
    uart_q.delete(); mosi0_q.delete(); resp0.delete();
    resp0.push_back(8'hC3);
    uart_send(8'hA2, 1'b1);
    uart_send(8'h5A, 1'b1);
    wait_reply(1, 5000);
    exp_blue = ~exp_blue;
    got = (uart_q.size() > 0) ? uart_q[0] : 8'h00;
    vec_cnt++;
    if (uart_q.size() != 1 || got !== 8'hC3) begin
      err_cnt++; $display("FAIL spi0_reply: got %0d bytes, 0x%02h want 1 byte 0xc3", uart_q.size(), got);
    end
    got = (mosi0_q.size() > 0) ? mosi0_q[0] : 8'h00;
    vec_cnt++;
    if (mosi0_q.size() != 1 || got !== 8'h5A) begin
      err_cnt++; $display("FAIL spi0_mosi: got %0d bytes, 0x%02h want 1 byte 0x5a", mosi0_q.size(), got);
    end
    vec_cnt++;
    if (per0_min != 48 || per0_max != 48) begin
      err_cnt++; $display("FAIL spi0_sclk_period: got min %0d max %0d want 48", per0_min, per0_max);
    end
    vec_cnt++;
    if (spi0_cs !== 1'b1 || green !== 1'b0) begin
      err_cnt++; $display("FAIL spi0_release: cs %b green %b want 1 0", spi0_cs, green);
    end
    vec_cnt++;
    if (blue !== exp_blue) begin
      err_cnt++; $display("FAIL spi0_blue: got %b want %b", blue, exp_blue);
    end
    vec_cnt++;
    if (act1 != 0) begin
      err_cnt++; $display("FAIL spi0_spi1_quiet: spi1 active %0d cycles want 0", act1);
    end
  endtask

  task automatic test_spi1_multi;
    logic [7:0] got;
    act0 = 0; cs1_rises = 0;
    uart_q.delete(); mosi1_q.delete(); resp1.delete();
    resp1.push_back(8'hFF);
    resp1.push_back(8'h7E);
    uart_send(8'hA1, 1'b1);
    uart_send(8'h03, 1'b1);
    wait_reply(1, 5000);
    exp_blue = ~exp_blue;
    got = (uart_q.size() > 0) ? uart_q[0] : 8'h00;
    vec_cnt++;
    if (got !== 8'hFF) begin
      err_cnt++; $display("FAIL fram_reply1: got 0x%02h want 0xff", got);
    end
    vec_cnt++;
    if (spi1_cs !== 1'b0 || red !== 1'b1) begin
      err_cnt++; $display("FAIL fram_hold: cs %b red %b want 0 1", spi1_cs, red);
    end
    uart_send(8'hA3, 1'b1);
    uart_send(8'h00, 1'b1);
    wait_reply(2, 5000);
    exp_blue = ~exp_blue;
    got = (uart_q.size() > 1) ? uart_q[1] : 8'h00;
    vec_cnt++;
    if (got !== 8'h7E) begin
      err_cnt++; $display("FAIL fram_reply2: got 0x%02h want 0x7e", got);
    end
    vec_cnt++;
    if (mosi1_q.size() != 2 || mosi1_q[0] !== 8'h03 || mosi1_q[1] !== 8'h00) begin
      err_cnt++; $display("FAIL fram_mosi: got %0d bytes want 0x03 0x00", mosi1_q.size());
    end
    vec_cnt++;
    if (spi1_cs !== 1'b1 || red !== 1'b0 || cs1_rises != 1) begin
      err_cnt++; $display("FAIL fram_release: cs %b red %b rises %0d want 1 0 1", spi1_cs, red, cs1_rises);
    end
    vec_cnt++;
    if (blue !== exp_blue || act0 != 0) begin
      err_cnt++; $display("FAIL fram_blue_spi0: blue %b spi0 act %0d want %b 0", blue, act0, exp_blue);
    end
  endtask

  task automatic test_ignore_and_switch;
    logic [7:0] got;
    act1 = 0; both_low = 0;
    uart_q.delete(); mosi0_q.delete(); resp0.delete(); resp1.delete();
    resp0.push_back(8'h96);
    uart_send(8'h11, 1'b1);
    uart_send(8'hA0, 1'b1);
    uart_send(8'h00, 1'b1);
    wait_reply(1, 5000);
    exp_blue = ~exp_blue;
    got = (uart_q.size() > 0) ? uart_q[0] : 8'h00;
    vec_cnt++;
    if (uart_q.size() != 1 || got !== 8'h96 || act1 != 0) begin
      err_cnt++; $display("FAIL ignore_reply: got %0d bytes 0x%02h spi1 act %0d want 1 byte 0x96 0", uart_q.size(), got, act1);
    end
    vec_cnt++;
    if (spi0_cs !== 1'b0 || green !== 1'b1) begin
      err_cnt++; $display("FAIL lora_hold: cs %b green %b want 0 1", spi0_cs, green);
    end
    resp1.push_back(8'h5F);
    uart_send(8'hA3, 1'b1);
    vec_cnt++;
    if (spi0_cs !== 1'b1 || spi1_cs !== 1'b1 || green !== 1'b0) begin
      err_cnt++; $display("FAIL switch_drop: spi0_cs %b spi1_cs %b green %b want 1 1 0", spi0_cs, spi1_cs, green);
    end
    uart_send(8'h00, 1'b1);
    wait_reply(2, 5000);
    exp_blue = ~exp_blue;
    got = (uart_q.size() > 1) ? uart_q[1] : 8'h00;
    vec_cnt++;
    if (got !== 8'h5F || spi1_cs !== 1'b1) begin
      err_cnt++; $display("FAIL switch_reply: got 0x%02h cs1 %b want 0x5f 1", got, spi1_cs);
    end
    vec_cnt++;
    if (cs0_rise_cyc >= cs1_fall_cyc || both_low != 0) begin
      err_cnt++; $display("FAIL switch_order: cs0 rise %0d cs1 fall %0d both low %0d", cs0_rise_cyc, cs1_fall_cyc, both_low);
    end
  endtask

  task automatic test_bad_stop;
    act0 = 0; act1 = 0;
    uart_q.delete();
    uart_send(8'hA2, 1'b0);
    uart_send(8'h00, 1'b1);
    repeat (2000) @(negedge CLK);
    vec_cnt++;
    if (act0 != 0 || act1 != 0 || uart_q.size() != 0) begin
      err_cnt++; $display("FAIL bad_stop: spi act %0d %0d uart bytes %0d want 0 0 0", act0, act1, uart_q.size());
    end
  endtask

  task automatic test_reset_mid_xfer;
    logic [7:0] got;
    int k;
    uart_q.delete(); mosi0_q.delete(); resp0.delete();
    resp0.push_back(8'h11);
    rises0 = 0;
    uart_send(8'hA2, 1'b1);
    uart_send(8'h5A, 1'b1);
    k = 0;
    while (rises0 < 3 && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    vec_cnt++;
    if (rises0 < 3) begin
      err_cnt++; $display("FAIL midx_start: sclk rises %0d want >=3", rises0);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    vec_cnt++;
    if (spi0_cs !== 1'b1 || spi0_sclk !== 1'b0 || spi0_mosi !== 1'b0 || blue !== 1'b0) begin
      err_cnt++; $display("FAIL midx_reset: cs %b sclk %b mosi %b blue %b want 1 0 0 0", spi0_cs, spi0_sclk, spi0_mosi, blue);
    end
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    exp_blue = 1'b0;
    repeat (10) @(negedge CLK);
    resp0.delete(); mosi0_q.delete(); uart_q.delete();
    resp0.push_back(8'h3C);
    uart_send(8'hA2, 1'b1);
    uart_send(8'hF0, 1'b1);
    wait_reply(1, 5000);
    exp_blue = ~exp_blue;
    got = (uart_q.size() > 0) ? uart_q[0] : 8'h00;
    vec_cnt++;
    if (got !== 8'h3C) begin
      err_cnt++; $display("FAIL midx_reply: got 0x%02h want 0x3c", got);
    end
    got = (mosi0_q.size() > 0) ? mosi0_q[0] : 8'h00;
    vec_cnt++;
    if (mosi0_q.size() != 1 || got !== 8'hF0 || blue !== exp_blue || spi0_cs !== 1'b1) begin
      err_cnt++; $display("FAIL midx_xfer: mosi 0x%02h (%0d bytes) blue %b cs %b want 0xf0 1 %b 1", got, mosi0_q.size(), blue, exp_blue, spi0_cs);
    end
    vec_cnt++;
    if (viol != 0) begin
      err_cnt++; $display("FAIL idle_port_quiet: got %0d cycles of sclk/mosi with cs high want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_spi0_single();
    test_spi1_multi();
    test_ignore_and_switch();
    test_bad_stop();
    test_reset_mid_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bsv_uart_spi_bridge.md
Name: bsv_uart_spi_bridge

Overview:
- Design-level core of the UP5K board, clocked from the 48 MHz internal oscillator.
- Bridges a UART host link to two SPI-mode-0 masters: SPI0 drives the LoRa radio, SPI1 drives the FRAM.
- Each host command performs one full-duplex SPI byte transfer; the received MISO byte is echoed back over UART.
- Drives RGB status LEDs.

Parameters:
- UART_DIV, 417, clk cycles per UART bit (48 MHz / 115200).
- SPI_HALF, 24, clk cycles per SCLK half-period (1 MHz SCLK).

Ports:
- CLK  in  1  system clock, 48 MHz.
- RST_N  in  1  reset, synchronous, active-high (the name is kept from the codebase; the polarity is high).
- blue  out  1  toggles on each completed SPI transfer (1 = LED on).
- green  out  1  1 while spi0_cs is asserted.
- red  out  1  1 while spi1_cs is asserted.
- spi0_sclk, spi0_mosi  out  1 each  LoRa SPI clock and data out.
- spi0_miso  in  1  LoRa SPI data in.
- spi0_cs  out  1  LoRa chip select, active-low.
- spi1_sclk, spi1_mosi  out  1 each  FRAM SPI clock and data out.
- spi1_miso  in  1  FRAM SPI data in.
- spi1_cs  out  1  FRAM chip select, active-low.
- serial_txd  out  1  UART TX, idle high.
- serial_rxd  in  1  UART RX, asynchronous.

Behaviour:
- Reset values: sclk=0, mosi=0, cs=1 on both SPI ports; serial_txd=1; all LEDs 0; FSM=IDLE; UART RX/TX idle.
- UART framing: 8N1, LSB first, UART_DIV cycles per bit.
- UART RX:
  - serial_rxd passes through a 2-flop synchronizer.
  - A falling edge starts a frame; the start bit is re-checked at UART_DIV/2 and the frame is aborted if the line is high.
  - Data bits are sampled every UART_DIV cycles from that point.
  - A stop bit of 0 discards the byte (framing error).
  - Valid bytes produce a 1-cycle rx_valid pulse.
- UART TX:
  - Start bit, 8 data bits, then stop bit, each held UART_DIV cycles.
  - Busy for 10*UART_DIV cycles.
- Command byte format: bits[7:4] must be 4'hA, otherwise the byte is ignored. bit0 = device (0 = SPI0, 1 = SPI1). bit1 = release CS after the transfer. bits[3:2] are ignored.
- FSM:
  - IDLE: a valid command byte latches dev/release and moves to WAIT_DATA.
  - WAIT_DATA: the next received byte becomes the TX data and the FSM moves to XFER. There is no timeout.
  - XFER: 8-bit SPI transfer on the selected port. On completion the FSM moves to RESP.
  - RESP: the MISO byte is loaded into UART TX. The FSM returns to IDLE when TX goes idle again.
  - Bytes received in XFER or RESP are dropped.
- SPI transfer (mode 0, MSB first):
  - If the selected CS is not already low, assert it, then wait SPI_HALF cycles before the first bit.
  - mosi presents the current bit while sclk is low.
  - sclk rises after SPI_HALF; miso is sampled on that rising edge.
  - sclk falls after another SPI_HALF; the shift happens on the falling edge.
  - After 8 bits sclk=0 and mosi=0.
  - If release=1, CS goes high SPI_HALF cycles after the last falling edge; otherwise CS stays low, so multi-byte transactions are supported.
- Only one CS is low at a time. Accepting a command for the other device forces the currently held CS high immediately.
- The unselected port keeps sclk=0 and mosi=0 at all times.
- blue toggles when XFER completes. green = ~spi0_cs and red = ~spi1_cs, combinational.
- Reset asserted mid-operation: everything returns to reset values on the next clock, CS high immediately, and any partial UART/SPI frame is abandoned.

Test Plan:
- Reset held 15 cycles, then released -> both cs=1, sclk=0, txd=1, LEDs 0, no activity for 10000 cycles.
- UART send 0xA2, 0x5A; spi0_miso model returns 0xC3 -> spi0_cs low, mosi pattern 0,1,0,1,1,0,1,0 on rising edges, SCLK period 48 cycles, cs high afterwards, blue=1, UART returns 0xC3, spi1 pins unchanged.
- UART send 0xA1, 0x03, then 0xA3, 0x00; FRAM returns 0xFF, 0x7E -> spi1_cs stays low between the two bytes, red=1 during the transaction, cs high after the second byte, UART returns 0xFF, 0x7E.
- UART send 0x11, then 0xA0, 0x00 -> 0x11 is ignored; one transfer on SPI0 with cs held low and green=1. Then send 0xA3, 0x00 -> spi0_cs goes high when the command is accepted, before spi1_cs falls.
- Byte with a bad stop bit sent in IDLE -> ignored, no SPI activity, no UART reply.
- Reset asserted mid-XFER -> cs=1 and sclk=0 next cycle; after release, a fresh command works normally.
